// File: rtl/fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream : drains the FIFO read port into a valid/ready stream via a
// 2-word buffer, framing packets of PKTLEN words.          Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_rd_stream #(
  parameter int DWID   = 32,
  parameter int AWID   = 10,
  parameter int RDLAT  = 0,
  parameter int PKTLEN = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  output logic            frdena,
  input  logic [DWID-1:0] frddat,
  input  logic [AWID-1:0] frdlev,
  output logic            ovalid,
  input  logic            ordy,
  output logic [DWID-1:0] odat,
  output logic            olast,
  output logic [31:0]     pktcnt
);

  localparam int            BW        = (PKTLEN > 1) ? $clog2(PKTLEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKTLEN - 1);

  logic [1:0]      occ;
  logic            infl;
  logic            cap;
  logic            pop;
  logic [2:0]      pend;
  logic [DWID-1:0] ent0;
  logic [DWID-1:0] ent1;
  logic [BW-1:0]   beat;

  assign pop    = ovalid & ordy;
  // Words already owned after this edge: buffered plus in flight, minus the one leaving.
  assign pend   = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  assign frdena = ~rst & ena & (frdlev != '0) & (pend < 3'd2);

  generate
    if (RDLAT == 0) begin : g_show_ahead
      assign cap  = frdena;
      assign infl = 1'b0;
    end else begin : g_delayed
      assign cap = infl;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) infl <= 1'b0;
        else     infl <= frdena;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      case ({cap, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= frddat;
          else             ent1 <= frddat;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Head leaves while a new word arrives: the new word lands behind the head.
          if (occ == 2'd1) begin
            ent0 <= frddat;
          end else begin
            ent0 <= ent1;
            ent1 <= frddat;
          end
        end
        default: ;
      endcase
    end
  end

  assign ovalid = (occ != 2'd0);
  assign odat   = ent0;
  assign olast  = ovalid & (beat == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat   <= '0;
      pktcnt <= 32'd0;
    end else if (pop) begin
      beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
      if (olast) pktcnt <= pktcnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_stream : drives a show-ahead and a registered-read instance from
// behavioural FIFOs and checks the delivered stream.       Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_rd_stream;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int PL0 = 4;
  localparam int PL1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ena = 1'b0;
  logic ordy = 1'b0;

  logic [1:0]         frdena, ovalid, olast;
  logic [1:0][DW-1:0] frddat, odat;
  logic [1:0][AW-1:0] frdlev;
  logic [1:0][31:0]   pktcnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fmem [2][0:1023];
  int            frd [2];
  int            fwr [2];
  logic [DW-1:0] lat1_q = '0;

  int            cyc = 0;
  int            nrd [2];
  int            uflow [2];
  int            stab_err [2];
  int            lg_n [2];
  logic [DW-1:0] lg_dat [2][0:1023];
  logic          lg_last [2][0:1023];
  int            lg_cyc [2][0:1023];
  logic          prev_hold [2];
  logic [DW-1:0] prev_dat [2];
  logic          prev_last [2];
  int            tot [2];

  always #5 clk = ~clk;

  fifo_rd_stream #(.DWID(DW), .AWID(AW), .RDLAT(0), .PKTLEN(PL0)) dut0 (
    .clk(clk), .rst(rst), .ena(ena), .frdena(frdena[0]), .frddat(frddat[0]),
    .frdlev(frdlev[0]), .ovalid(ovalid[0]), .ordy(ordy), .odat(odat[0]),
    .olast(olast[0]), .pktcnt(pktcnt[0]));

  fifo_rd_stream #(.DWID(DW), .AWID(AW), .RDLAT(1), .PKTLEN(PL1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena), .frdena(frdena[1]), .frddat(frddat[1]),
    .frdlev(frdlev[1]), .ovalid(ovalid[1]), .ordy(ordy), .odat(odat[1]),
    .olast(olast[1]), .pktcnt(pktcnt[1]));

  // Behavioural FIFOs: instance 0 is show-ahead, instance 1 returns data a cycle later.
  assign frddat[0] = fmem[0][frd[0]];
  assign frddat[1] = lat1_q;
  assign frdlev[0] = AW'(fwr[0] - frd[0]);
  assign frdlev[1] = AW'(fwr[1] - frd[1]);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) if (frdena[i]) frd[i] <= frd[i] + 1;
    if (frdena[1]) lat1_q <= fmem[1][frd[1]];
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        if (frdena[i]) nrd[i] <= nrd[i] + 1;
        if (frdena[i] && frdlev[i] == '0) uflow[i] <= uflow[i] + 1;
        if (prev_hold[i] && (!ovalid[i] || odat[i] !== prev_dat[i] || olast[i] !== prev_last[i]))
          stab_err[i] <= stab_err[i] + 1;
        if (ovalid[i] && ordy) begin
          lg_dat[i][lg_n[i]]  <= odat[i];
          lg_last[i][lg_n[i]] <= olast[i];
          lg_cyc[i][lg_n[i]]  <= cyc;
          lg_n[i]             <= lg_n[i] + 1;
        end
      end
      prev_hold[i] <= !rst && ovalid[i] && !ordy;
      prev_dat[i]  <= odat[i];
      prev_last[i] <= olast[i];
    end
  end

  function automatic int plen(input int i);
    return (i == 0) ? PL0 : PL1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [DW-1:0] v);
    fmem[i][fwr[i]] = v;
    fwr[i]++;
  endtask

  task automatic do_reset();
    ena = 1'b0; ordy = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) tot[i] = 0;
    tick();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 10; k++) begin push(0, 32'(k)); push(1, 32'(k)); end
    ena = 1'b1; ordy = 1'b1; rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (frdena[i] !== 1'b0) begin errors++; $display("FAIL reset_frdena dut%0d: got %0d want 0", i, frdena[i]); end
      checks++; if (ovalid[i] !== 1'b0) begin errors++; $display("FAIL reset_ovalid dut%0d: got %0d want 0", i, ovalid[i]); end
      checks++; if (odat[i] !== '0) begin errors++; $display("FAIL reset_odat dut%0d: got %0h want 0", i, odat[i]); end
      checks++; if (olast[i] !== 1'b0) begin errors++; $display("FAIL reset_olast dut%0d: got %0d want 0", i, olast[i]); end
      checks++; if (pktcnt[i] !== 32'd0) begin errors++; $display("FAIL reset_pktcnt dut%0d: got %0d want 0", i, pktcnt[i]); end
    end
    tick();
    ena = 1'b0; ordy = 1'b0; rst = 1'b0;
    for (int i = 0; i < 2; i++) tot[i] = 0;
    tick();
  endtask

  task automatic test_stream();
    int st[2]; int r0[2]; int c0;
    for (int i = 0; i < 2; i++) begin st[i] = lg_n[i]; r0[i] = nrd[i]; end
    ena = 1'b1; ordy = 1'b1; c0 = cyc;
    repeat (16) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (lg_n[i] - st[i] !== 10) begin errors++; $display("FAIL stream_count dut%0d: got %0d want 10", i, lg_n[i] - st[i]); end
      checks++; if (nrd[i] - r0[i] !== 10) begin errors++; $display("FAIL stream_reads dut%0d: got %0d want 10", i, nrd[i] - r0[i]); end
      for (int k = 0; k < 10; k++) begin
        checks++; if (lg_dat[i][st[i]+k] !== 32'(k)) begin errors++; $display("FAIL stream_data dut%0d word%0d: got %0h want %0h", i, k, lg_dat[i][st[i]+k], k); end
        checks++; if (lg_cyc[i][st[i]+k] !== c0 + 1 + i + k) begin errors++; $display("FAIL stream_timing dut%0d word%0d: got cycle %0d want %0d", i, k, lg_cyc[i][st[i]+k], c0 + 1 + i + k); end
        checks++; if (lg_last[i][st[i]+k] !== ((tot[i] + k) % plen(i) == plen(i) - 1)) begin errors++; $display("FAIL stream_last dut%0d word%0d: got %0d", i, k, lg_last[i][st[i]+k]); end
      end
      tot[i] += 10;
      checks++; if (pktcnt[i] !== 32'(tot[i] / plen(i))) begin errors++; $display("FAIL stream_pktcnt dut%0d: got %0d want %0d", i, pktcnt[i], tot[i] / plen(i)); end
      checks++; if (ovalid[i] !== 1'b0) begin errors++; $display("FAIL stream_idle dut%0d: got ovalid %0d want 0", i, ovalid[i]); end
    end
    ena = 1'b0;
  endtask

  task automatic test_packet();
    int st[2]; int b[2];
    do_reset();
    for (int i = 0; i < 2; i++) begin
      st[i] = lg_n[i]; b[i] = frd[i];
      for (int k = 0; k < 12; k++) push(i, $urandom);
    end
    ena = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (lg_n[0] - st[0] >= 12 && lg_n[1] - st[1] >= 12) break;
      ordy = 1'($urandom_range(0, 1));
      tick();
    end
    ordy = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (lg_n[i] - st[i] !== 12) begin errors++; $display("FAIL packet_count dut%0d: got %0d want 12", i, lg_n[i] - st[i]); end
      for (int k = 0; k < 12; k++) begin
        checks++; if (lg_dat[i][st[i]+k] !== fmem[i][b[i]+k]) begin errors++; $display("FAIL packet_data dut%0d word%0d: got %0h want %0h", i, k, lg_dat[i][st[i]+k], fmem[i][b[i]+k]); end
        checks++; if (lg_last[i][st[i]+k] !== ((tot[i] + k) % plen(i) == plen(i) - 1)) begin errors++; $display("FAIL packet_last dut%0d word%0d: got %0d", i, k, lg_last[i][st[i]+k]); end
      end
      tot[i] += 12;
      checks++; if (pktcnt[i] !== 32'(tot[i] / plen(i))) begin errors++; $display("FAIL packet_pktcnt dut%0d: got %0d want %0d", i, pktcnt[i], tot[i] / plen(i)); end
      checks++; if (stab_err[i] !== 0) begin errors++; $display("FAIL packet_hold dut%0d: got %0d unstable cycles want 0", i, stab_err[i]); end
    end
    ena = 1'b0;
  endtask

  task automatic test_backpressure();
    int st[2]; int b[2]; int r0[2];
    for (int i = 0; i < 2; i++) begin
      st[i] = lg_n[i]; b[i] = frd[i]; r0[i] = nrd[i];
      for (int k = 0; k < 100; k++) push(i, $urandom);
    end
    ordy = 1'b0; ena = 1'b1;
    repeat (20) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (nrd[i] - r0[i] !== 2) begin errors++; $display("FAIL bp_reads dut%0d: got %0d want 2", i, nrd[i] - r0[i]); end
      checks++; if (frdlev[i] !== AW'(98)) begin errors++; $display("FAIL bp_level dut%0d: got %0d want 98", i, frdlev[i]); end
      checks++; if (ovalid[i] !== 1'b1) begin errors++; $display("FAIL bp_ovalid dut%0d: got %0d want 1", i, ovalid[i]); end
    end
    ordy = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (lg_n[0] - st[0] >= 100 && lg_n[1] - st[1] >= 100) break;
      tick();
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (lg_n[i] - st[i] !== 100) begin errors++; $display("FAIL bp_count dut%0d: got %0d want 100", i, lg_n[i] - st[i]); end
      for (int k = 0; k < 100; k++) begin
        checks++; if (lg_dat[i][st[i]+k] !== fmem[i][b[i]+k]) begin errors++; $display("FAIL bp_data dut%0d word%0d: got %0h want %0h", i, k, lg_dat[i][st[i]+k], fmem[i][b[i]+k]); end
        checks++; if (lg_last[i][st[i]+k] !== ((tot[i] + k) % plen(i) == plen(i) - 1)) begin errors++; $display("FAIL bp_last dut%0d word%0d: got %0d", i, k, lg_last[i][st[i]+k]); end
      end
      tot[i] += 100;
      checks++; if (pktcnt[i] !== 32'(tot[i] / plen(i))) begin errors++; $display("FAIL bp_pktcnt dut%0d: got %0d want %0d", i, pktcnt[i], tot[i] / plen(i)); end
      checks++; if (ovalid[i] !== 1'b0) begin errors++; $display("FAIL bp_drained dut%0d: got ovalid %0d want 0", i, ovalid[i]); end
      checks++; if (uflow[i] !== 0) begin errors++; $display("FAIL bp_underflow dut%0d: got %0d reads at empty want 0", i, uflow[i]); end
      checks++; if (stab_err[i] !== 0) begin errors++; $display("FAIL bp_hold dut%0d: got %0d unstable cycles want 0", i, stab_err[i]); end
    end
  endtask

  task automatic test_ena_drop();
    int st[2]; int b[2]; int r0[2]; int r1[2];
    for (int i = 0; i < 2; i++) begin
      st[i] = lg_n[i]; b[i] = frd[i]; r0[i] = nrd[i];
      for (int k = 0; k < 20; k++) push(i, $urandom);
    end
    ordy = 1'b1; ena = 1'b1;
    repeat (4) tick();
    ena = 1'b0;
    for (int i = 0; i < 2; i++) r1[i] = nrd[i];
    repeat (10) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (r1[i] - r0[i] !== 4) begin errors++; $display("FAIL drop_reads dut%0d: got %0d want 4", i, r1[i] - r0[i]); end
      checks++; if (nrd[i] !== r1[i]) begin errors++; $display("FAIL drop_noread dut%0d: got %0d extra reads want 0", i, nrd[i] - r1[i]); end
      checks++; if (lg_n[i] - st[i] !== 4) begin errors++; $display("FAIL drop_count dut%0d: got %0d want 4", i, lg_n[i] - st[i]); end
      checks++; if (frdlev[i] !== AW'(16)) begin errors++; $display("FAIL drop_level dut%0d: got %0d want 16", i, frdlev[i]); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (lg_dat[i][st[i]+k] !== fmem[i][b[i]+k]) begin errors++; $display("FAIL drop_data dut%0d word%0d: got %0h want %0h", i, k, lg_dat[i][st[i]+k], fmem[i][b[i]+k]); end
      end
      checks++; if (ovalid[i] !== 1'b0) begin errors++; $display("FAIL drop_idle dut%0d: got ovalid %0d want 0", i, ovalid[i]); end
      tot[i] += 4;
    end
  endtask

  task automatic test_reset_mid();
    int st[2]; int b[2]; int n[2];
    do_reset();
    for (int i = 0; i < 2; i++) begin
      st[i] = lg_n[i];
      for (int k = 0; k < 10; k++) push(i, $urandom);
    end
    ena = 1'b1; ordy = 1'b0;
    repeat (5) tick();
    ordy = 1'b1;
    repeat (2) tick();
    ordy = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (lg_n[i] - st[i] !== 2) begin errors++; $display("FAIL mid_pre_count dut%0d: got %0d want 2", i, lg_n[i] - st[i]); end
      checks++; if (ovalid[i] !== 1'b1) begin errors++; $display("FAIL mid_pre_ovalid dut%0d: got %0d want 1", i, ovalid[i]); end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (ovalid[i] !== 1'b0) begin errors++; $display("FAIL mid_rst_ovalid dut%0d: got %0d want 0", i, ovalid[i]); end
      checks++; if (pktcnt[i] !== 32'd0) begin errors++; $display("FAIL mid_rst_pktcnt dut%0d: got %0d want 0", i, pktcnt[i]); end
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tot[i] = 0; st[i] = lg_n[i]; b[i] = frd[i]; n[i] = fwr[i] - frd[i];
    end
    ordy = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (lg_n[0] - st[0] >= n[0] && lg_n[1] - st[1] >= n[1]) break;
      tick();
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      checks++; if (lg_n[i] - st[i] !== n[i]) begin errors++; $display("FAIL mid_count dut%0d: got %0d want %0d", i, lg_n[i] - st[i], n[i]); end
      for (int k = 0; k < n[i]; k++) begin
        checks++; if (lg_dat[i][st[i]+k] !== fmem[i][b[i]+k]) begin errors++; $display("FAIL mid_data dut%0d word%0d: got %0h want %0h", i, k, lg_dat[i][st[i]+k], fmem[i][b[i]+k]); end
        checks++; if (lg_last[i][st[i]+k] !== (k % plen(i) == plen(i) - 1)) begin errors++; $display("FAIL mid_last dut%0d word%0d: got %0d", i, k, lg_last[i][st[i]+k]); end
      end
      checks++; if (pktcnt[i] !== 32'(n[i] / plen(i))) begin errors++; $display("FAIL mid_pktcnt dut%0d: got %0d want %0d", i, pktcnt[i], n[i] / plen(i)); end
      checks++; if (ovalid[i] !== 1'b0) begin errors++; $display("FAIL mid_idle dut%0d: got ovalid %0d want 0", i, ovalid[i]); end
    end
    ena = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_stream();
    test_packet();
    test_backpressure();
    test_ena_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got %0d cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
